// File: rtl/hack_alu_ctrl_if.sv
// Instruction, ALU and data-memory signals between the Hack controller and its
// environment. The slave modport is the controller's side.
interface hack_alu_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 15
);
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic              zx, nx, zy, ny, f, no;
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              zr, ng;
  logic [PC_W-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;
  logic              mem_we;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] d_out;

  modport slave (
    input  instr_valid, instr, alu_out, zr, ng, mem_in,
    output instr_ready, zx, nx, zy, ny, f, no, alu_x, alu_y,
           mem_addr, mem_out, mem_we, pc, a_out, d_out
  );

  modport master (
    output instr_valid, instr, alu_out, zr, ng, mem_in,
    input  instr_ready, zx, nx, zy, ny, f, no, alu_x, alu_y,
           mem_addr, mem_out, mem_we, pc, a_out, d_out
  );
endinterface

// File: rtl/hack_alu_ctrl.sv
// Hack CPU control path: FETCH/EXEC/WB sequencer that drives an external ALU,
// owns A, D and PC, and performs destination writeback and jump resolution.
module hack_alu_ctrl #(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  hack_alu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {FETCH, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir, a_q, d_q, result;
  logic [PC_W-1:0]   pc_q;
  logic              zr_q, ng_q;

  logic              accept;
  logic              exec_a;
  logic              exec_c;
  logic              in_wb;
  logic              jump;
  logic [PC_W-1:0]   pc_inc;

  // Next-state and per-state strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    exec_a    = 1'b0;
    exec_c    = 1'b0;
    in_wb     = 1'b0;
    unique case (state)
      FETCH: begin
        accept = bus.instr_valid;
        if (bus.instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        exec_a    = ~ir[15];
        exec_c    = ir[15];
        state_nxt = ir[15] ? WB : FETCH;
      end
      WB: begin
        in_wb     = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  assign pc_inc = pc_q + PC_W'(1);

  // jump and mem_addr see A as it was before this cycle's writeback
  assign jump = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~zr_q & ~ng_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= '0;
      a_q    <= '0;
      d_q    <= '0;
      result <= '0;
      zr_q   <= 1'b0;
      ng_q   <= 1'b0;
      pc_q   <= RESET_PC;
    end else begin
      if (accept) ir <= bus.instr;
      if (exec_a) begin
        a_q  <= {1'b0, ir[14:0]};
        pc_q <= pc_inc;
      end
      if (exec_c) begin
        result <= bus.alu_out;
        zr_q   <= bus.zr;
        ng_q   <= bus.ng;
      end
      if (in_wb) begin
        if (ir[4]) d_q <= result;
        if (ir[5]) a_q <= result;
        pc_q <= jump ? a_q[PC_W-1:0] : pc_inc;
      end
    end
  end

  assign bus.instr_ready = (state == FETCH);

  assign bus.zx    = exec_c & ir[11];
  assign bus.nx    = exec_c & ir[10];
  assign bus.zy    = exec_c & ir[9];
  assign bus.ny    = exec_c & ir[8];
  assign bus.f     = exec_c & ir[7];
  assign bus.no    = exec_c & ir[6];
  assign bus.alu_x = exec_c ? d_q : '0;
  assign bus.alu_y = exec_c ? (ir[12] ? bus.mem_in : a_q) : '0;

  // Decoded from state so it drops as soon as reset forces FETCH
  assign bus.mem_we   = in_wb & ir[3];
  assign bus.mem_addr = a_q[PC_W-1:0];
  assign bus.mem_out  = result;

  assign bus.pc    = pc_q;
  assign bus.a_out = a_q;
  assign bus.d_out = d_q;

endmodule

// File: tb/tb_hack_alu_ctrl.sv
// Bench for hack_alu_ctrl: Hack ALU and data memory models around the DUT,
// directed vector table, hand sequences for reset/wrap, random vs. ISA model.
module tb_hack_alu_ctrl;

  logic clk, rst_n, mem_clr;
  int   checks = 0;
  int   errors = 0;

  hack_alu_ctrl_if #(.DATA_W(16), .PC_W(15)) bus ();

  hack_alu_ctrl #(.DATA_W(16), .PC_W(15), .RESET_PC(15'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack ALU: c = {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] alu_f(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  logic [15:0] alu_r;
  assign alu_r       = alu_f({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, bus.alu_x, bus.alu_y);
  assign bus.alu_out = alu_r;
  assign bus.zr      = (alu_r == 16'h0);
  assign bus.ng      = alu_r[15];

  // Data memory, aliased to 256 words
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
    else if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_out;
  end
  assign bus.mem_in = mem[bus.mem_addr[7:0]];

  // ISA-level reference
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [15:0] m_mem [0:255];

  task automatic model_step(input logic [15:0] ins, output int we, output logic [14:0] wa, output logic [15:0] wd);
    logic [15:0] y, r, old_a;
    logic        neg, zero, jmp;
    we = 0; wa = '0; wd = '0;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      old_a = m_a;
      y     = ins[12] ? m_mem[old_a[7:0]] : old_a;
      r     = alu_f(ins[11:6], m_d, y);
      neg   = r[15];
      zero  = (r == 16'h0);
      if (ins[3]) begin
        we = 1; wa = old_a[14:0]; wd = r;
        m_mem[old_a[7:0]] = r;
      end
      if (ins[4]) m_d = r;
      if (ins[5]) m_a = r;
      jmp  = (ins[2] & neg) | (ins[1] & zero) | (ins[0] & ~neg & ~zero);
      m_pc = jmp ? old_a[14:0] : m_pc + 15'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_clr = 1'b1; bus.instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
    m_a = '0; m_d = '0; m_pc = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  // Issue one instruction from a negedge; return at the negedge where ready is back.
  task automatic send(input logic [15:0] ins, output int we_cnt, output logic [14:0] wa,
                      output logic [15:0] wd, output logic [5:0] ctrl, output logic [15:0] ay,
                      output int lat);
    int w;
    we_cnt = 0; wa = '0; wd = '0; lat = 0;
    w = 0;
    while (!bus.instr_ready && w < 8) begin @(negedge clk); w++; end
    if (!bus.instr_ready) chk("ready_timeout", 0, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    ctrl = {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
    ay   = bus.alu_y;
    while (!bus.instr_ready && lat < 8) begin
      if (bus.mem_we) begin we_cnt++; wa = bus.mem_addr; wd = bus.mem_out; end
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a, d;
    logic [14:0] pc;
    int          we;
    logic [14:0] wa;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic [15:0] i, input logic [15:0] a, input logic [15:0] d,
                              input logic [14:0] pc, input int we, input logic [14:0] wa, input logic [15:0] wd);
    vec_t v;
    v.instr = i; v.a = a; v.d = d; v.pc = pc; v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  initial begin
    int          we_cnt, lat, mwe;
    logic [14:0] wa, mwa;
    logic [15:0] wd, mwd, ay, ins;
    logic [5:0]  ctrl;

    tbl[0]  = mk(16'h0015, 16'h0015, 16'h0000, 15'h001, 0, 15'h0,   16'h0);
    tbl[1]  = mk(16'hEC10, 16'h0015, 16'h0015, 15'h002, 0, 15'h0,   16'h0);
    tbl[2]  = mk(16'h0064, 16'h0064, 16'h0015, 15'h003, 0, 15'h0,   16'h0);
    tbl[3]  = mk(16'hE7C8, 16'h0064, 16'h0015, 15'h004, 1, 15'h064, 16'h0016);
    tbl[4]  = mk(16'h0005, 16'h0005, 16'h0015, 15'h005, 0, 15'h0,   16'h0);
    tbl[5]  = mk(16'hEC10, 16'h0005, 16'h0005, 15'h006, 0, 15'h0,   16'h0);
    tbl[6]  = mk(16'h0040, 16'h0040, 16'h0005, 15'h007, 0, 15'h0,   16'h0);
    tbl[7]  = mk(16'hE301, 16'h0040, 16'h0005, 15'h040, 0, 15'h0,   16'h0);
    tbl[8]  = mk(16'h0000, 16'h0000, 16'h0005, 15'h041, 0, 15'h0,   16'h0);
    tbl[9]  = mk(16'hEC10, 16'h0000, 16'h0000, 15'h042, 0, 15'h0,   16'h0);
    tbl[10] = mk(16'h0040, 16'h0040, 16'h0000, 15'h043, 0, 15'h0,   16'h0);
    tbl[11] = mk(16'hE301, 16'h0040, 16'h0000, 15'h044, 0, 15'h0,   16'h0);
    tbl[12] = mk(16'hEE90, 16'h0040, 16'hFFFF, 15'h045, 0, 15'h0,   16'h0);
    tbl[13] = mk(16'h0040, 16'h0040, 16'hFFFF, 15'h046, 0, 15'h0,   16'h0);
    tbl[14] = mk(16'hE301, 16'h0040, 16'hFFFF, 15'h047, 0, 15'h0,   16'h0);
    tbl[15] = mk(16'h0007, 16'h0007, 16'hFFFF, 15'h048, 0, 15'h0,   16'h0);
    tbl[16] = mk(16'hEC10, 16'h0007, 16'h0007, 15'h049, 0, 15'h0,   16'h0);
    tbl[17] = mk(16'h0010, 16'h0010, 16'h0007, 15'h04A, 0, 15'h0,   16'h0);
    tbl[18] = mk(16'hE308, 16'h0010, 16'h0007, 15'h04B, 1, 15'h010, 16'h0007);
    tbl[19] = mk(16'hFCA8, 16'h0006, 16'h0007, 15'h04C, 1, 15'h010, 16'h0006);
    tbl[20] = mk(16'hEA87, 16'h0006, 16'h0007, 15'h006, 0, 15'h0,   16'h0);

    // Reset held with a valid instruction waiting
    rst_n = 1'b0; mem_clr = 1'b1;
    bus.instr_valid = 1'b1; bus.instr = 16'h0015;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_a", 32'(bus.a_out), 0);
    chk("rst_d", 32'(bus.d_out), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_ctrl", {26'h0, bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, 0);
    chk("rst_alu_xy", {bus.alu_x, bus.alu_y}, 0);
    chk("rst_ready", 32'(bus.instr_ready), 1);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    chk("first_accept", 32'(bus.instr_ready), 0);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("first_a", 32'(bus.a_out), 32'h15);
    chk("first_pc", 32'(bus.pc), 1);

    send(16'hEC10, we_cnt, wa, wd, ctrl, ay, lat);
    chk("exec_ctrl_dA", 32'(ctrl), 32'b110000);
    chk("exec_alu_y", 32'(ay), 32'd21);
    chk("dA_d", 32'(bus.d_out), 32'd21);
    chk("dA_pc", 32'(bus.pc), 2);
    chk("dA_lat", 32'(lat), 3);

    // Directed table
    do_reset();
    for (int i = 0; i < 21; i++) begin
      send(tbl[i].instr, we_cnt, wa, wd, ctrl, ay, lat);
      chk($sformatf("tbl%0d_a", i), 32'(bus.a_out), 32'(tbl[i].a));
      chk($sformatf("tbl%0d_d", i), 32'(bus.d_out), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_pc", i), 32'(bus.pc), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_we", i), 32'(we_cnt), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), tbl[i].instr[15] ? 32'd3 : 32'd2);
      if (tbl[i].we != 0) begin
        chk($sformatf("tbl%0d_waddr", i), 32'(wa), 32'(tbl[i].wa));
        chk($sformatf("tbl%0d_wdata", i), 32'(wd), 32'(tbl[i].wd));
      end
    end

    // PC wrap at 0x7FFF
    do_reset();
    send(16'h7FFF, we_cnt, wa, wd, ctrl, ay, lat);
    send(16'hEA87, we_cnt, wa, wd, ctrl, ay, lat);
    chk("wrap_jmp_pc", 32'(bus.pc), 32'h7FFF);
    send(16'h0001, we_cnt, wa, wd, ctrl, ay, lat);
    chk("wrap_pc", 32'(bus.pc), 0);

    // Reset during WB of M=D
    do_reset();
    send(16'h0005, we_cnt, wa, wd, ctrl, ay, lat);
    send(16'hEC10, we_cnt, wa, wd, ctrl, ay, lat);
    send(16'h0020, we_cnt, wa, wd, ctrl, ay, lat);
    bus.instr_valid = 1'b1; bus.instr = 16'hE308;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("wb_we", 32'(bus.mem_we), 1);
    chk("wb_addr", 32'(bus.mem_addr), 32'h20);
    chk("wb_data", 32'(bus.mem_out), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwb_we", 32'(bus.mem_we), 0);
    chk("rstwb_ready", 32'(bus.instr_ready), 1);
    chk("rstwb_pc", 32'(bus.pc), 0);
    chk("rstwb_d", 32'(bus.d_out), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rstwb_mem", 32'(mem[8'h20]), 0);
    rst_n = 1'b1;

    // Random instructions against the ISA model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 4) ins = {1'b0, 15'($urandom)};
      else                          ins = {3'b111, 13'($urandom)};
      send(ins, we_cnt, wa, wd, ctrl, ay, lat);
      model_step(ins, mwe, mwa, mwd);
      chk($sformatf("rnd%0d_%h_a", n, ins), 32'(bus.a_out), 32'(m_a));
      chk($sformatf("rnd%0d_%h_d", n, ins), 32'(bus.d_out), 32'(m_d));
      chk($sformatf("rnd%0d_%h_pc", n, ins), 32'(bus.pc), 32'(m_pc));
      chk($sformatf("rnd%0d_%h_we", n, ins), 32'(we_cnt), 32'(mwe));
      chk($sformatf("rnd%0d_%h_lat", n, ins), 32'(lat), ins[15] ? 32'd3 : 32'd2);
      if (mwe != 0) begin
        chk($sformatf("rnd%0d_%h_waddr", n, ins), 32'(wa), 32'(mwa));
        chk($sformatf("rnd%0d_%h_wdata", n, ins), 32'(wd), 32'(mwd));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
